// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - valid/ready data-memory responder with programmable wait states
// Optional per-byte store enables are built when DMEM_BYTE_WRITE_EN is defined.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_write_data,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [3:0]  req_byte_en,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_read_data,
  output logic        resp_error
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     wait_cnt;
  logic           hold_write;
  logic [31:0]    hold_addr;
  logic [31:0]    hold_wdata;
  logic [3:0]     hold_be;
  logic [3:0]     wr_mask;
  logic           accept;
  logic           commit;
  logic           addr_err;
  logic [AW-1:0]  word_idx;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept   = (state == S_IDLE) && req_valid;
  assign commit   = (state == S_WAIT) && (wait_cnt == 4'd0);
  assign word_idx = hold_addr[AW+1:2];
  // Anything above the array's word index, or a non-word offset, is an error.
  assign addr_err = (hold_addr[1:0] != 2'b00) || ((hold_addr >> (AW + 2)) != 32'd0);

`ifdef DMEM_BYTE_WRITE_EN
  assign wr_mask = hold_be;
`else
  assign wr_mask = 4'hF;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid)             state_nxt = S_WAIT;
      S_WAIT: if (wait_cnt == 4'd0)      state_nxt = S_RESP;
      S_RESP: if (resp_ready)            state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt   <= 4'd0;
      hold_write <= 1'b0;
      hold_addr  <= 32'd0;
      hold_wdata <= 32'd0;
      hold_be    <= 4'd0;
    end else if (accept) begin
      wait_cnt   <= WAIT_INIT;
      hold_write <= req_write;
      hold_addr  <= req_addr;
      hold_wdata <= req_write_data;
`ifdef DMEM_BYTE_WRITE_EN
      hold_be    <= req_byte_en;
`else
      hold_be    <= 4'hF;
`endif
    end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Response fields change only at the commit edge, so they stay stable in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_read_data <= 32'd0;
      resp_error     <= 1'b0;
    end else if (commit) begin
      resp_error     <= addr_err;
      resp_read_data <= (!hold_write && !addr_err) ? mem[word_idx] : 32'd0;
    end
  end

  // Array is not reset; reset forces the FSM out of WAIT so pending stores never commit.
  always_ff @(posedge clk) begin
    if (commit && hold_write && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) begin
          mem[word_idx][8*i +: 8] <= hold_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_write_data = 32'd0;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  req_byte_en = 4'd0;
`endif
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_read_data;
  logic        resp_error;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_accept = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_write_data (req_write_data),
`ifdef DMEM_BYTE_WRITE_EN
    .req_byte_en    (req_byte_en),
`endif
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_read_data (resp_read_data),
    .resp_error     (resp_error)
  );

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int stall, input string name);
    exp_t        e;
    exp_t        got;
    logic [3:0]  mask;
    int          idx;
    int          lat;
    int          n;
    logic [31:0] held_d;
    logic        held_e;
`ifdef DMEM_BYTE_WRITE_EN
    mask = be;
`else
    mask = 4'hF;
`endif
    e.err  = (addr[1:0] != 2'b00) || (addr[31:8] != 24'd0);
    e.data = 32'd0;
    idx    = int'(addr[7:2]);
    if (!e.err) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (mask[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        e.data = model[idx];
      end
    end
    sb.push_back(e);

    req_valid      = 1'b1;
    req_write      = wr;
    req_addr       = addr;
    req_write_data = wdata;
`ifdef DMEM_BYTE_WRITE_EN
    req_byte_en    = be;
`endif
    resp_ready     = (stall == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!req_ready) begin
      errors++; $display("FAIL %s accept_timeout req_ready=%0b required=1", name, req_ready);
    end
    @(posedge clk); #1;
    last_accept    = cycle;
    req_valid      = 1'b0;
    req_addr       = $urandom;
    req_write_data = $urandom;
    req_write      = ~wr;

    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    got.data = resp_read_data;
    got.err  = resp_error;
    e = sb.pop_front();
    checks++;
    if (lat !== LAT) begin
      errors++; $display("FAIL %s latency got=%0d required=%0d", name, lat, LAT);
    end
    checks++;
    if (got.data !== e.data) begin
      errors++; $display("FAIL %s read_data got=%h required=%h", name, got.data, e.data);
    end
    checks++;
    if (got.err !== e.err) begin
      errors++; $display("FAIL %s error got=%b required=%b", name, got.err, e.err);
    end

    if (stall > 0) begin
      held_d = resp_read_data;
      held_e = resp_error;
      for (int s = 0; s < stall; s++) begin
        req_valid      = 1'b1;
        req_write      = 1'b1;
        req_addr       = 32'h10;
        req_write_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_read_data !== held_d || resp_error !== held_e) begin
          errors++;
          $display("FAIL %s stall_hold vld=%b rdy=%b data=%h err=%b required vld=1 rdy=0 data=%h err=%b",
                   name, resp_valid, req_ready, resp_read_data, resp_error, held_d, held_e);
        end
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL %s return_idle vld=%b rdy=%b required vld=0 rdy=1", name, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_read_data !== 32'd0 || resp_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state rdy=%b vld=%b data=%h err=%b required rdy=1 vld=0 data=0 err=0",
               req_ready, resp_valid, resp_read_data, resp_error);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset rdy=%b vld=%b required rdy=1 vld=0", req_ready, resp_valid);
    end
  endtask

  task automatic test_store_load();
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, "store_10");
    do_req(1'b0, 32'h10, 32'd0, 4'hF, 0, "load_10");
    do_req(1'b1, 32'hFC, 32'h0BAD_F00D, 4'hF, 0, "store_top");
    do_req(1'b0, 32'hFC, 32'd0, 4'hF, 0, "load_top");
  endtask

  task automatic test_backpressure();
    do_req(1'b0, 32'h10, 32'd0, 4'hF, 5, "load_stall");
    do_req(1'b0, 32'h10, 32'd0, 4'hF, 0, "load_after_stall");
  endtask

  task automatic test_errors();
    do_req(1'b1, 32'h0, 32'h5A5A_0000, 4'hF, 0, "store_0");
    do_req(1'b0, 32'h102, 32'd0, 4'hF, 0, "load_misaligned");
    do_req(1'b1, 32'h100, 32'h1111_1111, 4'hF, 0, "store_oor");
    do_req(1'b0, 32'h0, 32'd0, 4'hF, 0, "load_0_unchanged");
    do_req(1'b1, 32'h8000_0000, 32'h2222_2222, 4'hF, 1, "store_high_oor");
  endtask

  task automatic test_reset_mid_wait();
    do_req(1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, 0, "store_4_prior");
    req_valid      = 1'b1;
    req_write      = 1'b1;
    req_addr       = 32'h4;
    req_write_data = 32'h1234_5678;
`ifdef DMEM_BYTE_WRITE_EN
    req_byte_en    = 4'hF;
`endif
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_wait rdy=%b vld=%b required rdy=1 vld=0", req_ready, resp_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    do_req(1'b0, 32'h4, 32'd0, 4'hF, 0, "load_4_after_abort");
  endtask

  task automatic test_back_to_back();
    int first;
    do_req(1'b1, 32'h20, 32'hA5A5_0001, 4'hF, 0, "b2b_0");
    first = last_accept;
    do_req(1'b1, 32'h24, 32'hA5A5_0002, 4'hF, 0, "b2b_1");
    checks++;
    if (last_accept - first !== LAT + 2) begin
      errors++; $display("FAIL b2b_spacing got=%0d required=%0d", last_accept - first, LAT + 2);
    end
    first = last_accept;
    do_req(1'b0, 32'h20, 32'd0, 4'hF, 0, "b2b_2");
    checks++;
    if (last_accept - first !== LAT + 2) begin
      errors++; $display("FAIL b2b_spacing2 got=%0d required=%0d", last_accept - first, LAT + 2);
    end
    do_req(1'b0, 32'h24, 32'd0, 4'hF, 0, "b2b_3");
  endtask

`ifdef DMEM_BYTE_WRITE_EN
  task automatic test_byte_en();
    do_req(1'b1, 32'h8, 32'hAABB_CCDD, 4'hF, 0, "be_init");
    do_req(1'b1, 32'h8, 32'h1122_3344, 4'b0101, 0, "be_0101");
    do_req(1'b0, 32'h8, 32'd0, 4'b0000, 0, "be_load");
    checks++;
    if (model[2] !== 32'hAA22_CC44) begin
      errors++; $display("FAIL be_model got=%h required=%h", model[2], 32'hAA22_CC44);
    end
    do_req(1'b1, 32'h8, 32'hFFFF_FFFF, 4'b0000, 0, "be_0000");
    do_req(1'b0, 32'h8, 32'd0, 4'hF, 0, "be_load_unchanged");
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    test_errors();
    test_reset_mid_wait();
    test_back_to_back();
`ifdef DMEM_BYTE_WRITE_EN
    test_byte_en();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port when the port runs over a valid/ready request–response handshake instead of a single-cycle combinational array. It accepts one load or store at a time and models a programmable number of wait states. It returns read data or a write acknowledgement with an error flag. It sits between the core's load/store unit (initiator) and a word-organised RAM array it owns internally.

## Interface
- DEPTH_WORDS, 64, number of 32-bit words; power of two, ≥ 2; AW = clog2(DEPTH_WORDS)
- LATENCY, 2, wait-state cycles between acceptance and response; legal range 1–15
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- req_valid  input  1  initiator has a request
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_write_data  input  32  store data
- req_byte_en  input  4  per-byte store enable; present only with DMEM_BYTE_WRITE_EN
- resp_valid  output  1  response available
- resp_ready  input  1  initiator accepts response
- resp_read_data  output  32  load data (0 for stores and errors)
- resp_error  output  1  request was misaligned or out of range

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: counting wait states.
  - RESP: resp_valid=1.
- IDLE→WAIT when req_valid & req_ready at a rising edge (acceptance).
  - On acceptance, latch req_write, req_addr, req_write_data (and req_byte_en) into holding registers.
  - Load wait counter with LATENCY-1.
- WAIT: decrement the counter each cycle. At the edge where the counter is 0:
  - perform the access;
  - register resp_read_data and resp_error;
  - go to RESP.
- RESP: hold resp_valid, resp_read_data and resp_error stable until resp_ready=1 at an edge, then go to IDLE. resp_ready is ignored outside RESP.
- Exactly one outstanding request. req_ready=0 in WAIT and RESP. Input changes there are ignored.
- Word index = latched addr[AW+1:2].
- Error when either condition holds (no write, read data 0):
  - addr[1:0] != 0;
  - addr[31:AW+2] != 0.
- Load: resp_read_data = mem[index]. Store: mem[index] updated at the WAIT→RESP edge; resp_read_data = 0.
- A load issued after a store to the same word returns the stored value, because accesses are serialised.
- Memory contents are not reset. Simulation initial contents are X unless a bench preloads them.

## Timing
- Reset (reset=0, asynchronous), all outputs and state:
  - state=IDLE, req_ready=1;
  - resp_valid=0, resp_read_data=0, resp_error=0;
  - counter=0, holding registers=0.
- Reset mid-operation aborts the transaction. A store not yet committed (still in WAIT) never reaches the array.
- Reset release is taken synchronously by design: the first acceptance is possible at the first rising edge with reset=1.
- Acceptance at edge k → resp_valid high after edge k+LATENCY (LATENCY cycles in WAIT).
- Response handshake at edge m → req_ready high after edge m. A new request is accepted at edge m+1 at the earliest.
- Best-case throughput with resp_ready tied high: one request per LATENCY+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- DMEM_BYTE_WRITE_EN defined:
  - req_byte_en port exists.
  - A store writes only the bytes with req_byte_en[i]=1 (bit i covers data[8i+7:8i]).
  - req_byte_en=0000 on a store is legal: no change, normal response.
  - Loads ignore req_byte_en.
- DMEM_BYTE_WRITE_EN undefined: no req_byte_en port. Every store writes all 32 bits.

## Test plan
- Reset then idle: reset=0 for 3 cycles, release → req_ready=1, resp_valid=0, resp_read_data=0, resp_error=0.
- Store then load, LATENCY=2, resp_ready=1:
  - store 0xDEADBEEF to 0x0000_0010 → resp_valid exactly 2 cycles after acceptance, resp_error=0;
  - then load 0x10 → resp_read_data=0xDEADBEEF.
- Backpressure:
  - load with resp_ready=0 for 5 cycles → resp_valid and data held stable, req_ready=0 throughout, new req_valid ignored;
  - raise resp_ready → IDLE next cycle.
- Errors, DEPTH_WORDS=64:
  - load 0x0000_0102 → resp_error=1, data 0;
  - store to 0x0000_0100 → resp_error=1, and word 0 is unchanged on a subsequent load.
- Reset mid-WAIT: store 0x12345678 to 0x4, assert reset one cycle after acceptance → later load of 0x4 returns the prior value, not 0x12345678.
- With DMEM_BYTE_WRITE_EN:
  - word 0x8 = 0xAABBCCDD; store 0x11223344 with byte_en=0101 → load returns 0xAA22CC44;
  - byte_en=0000 leaves the word unchanged.
